// File: rtl/bcd_display_converter_if.sv
`default_nettype none
// ============================================================================
// Module : bcd_display_converter_if
// Start/busy/done request bus and display outputs of the BCD converter.
// Rev    : 1.0
// ============================================================================
interface bcd_display_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  i_start;
  logic [WIDTH-1:0]      i_bin;
  logic                  o_busy;
  logic                  o_done;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_overflow;
  logic [7*DIGITS-1:0]   o_hex;

  modport master (
    output i_start, i_bin,
    input  o_busy, o_done, o_bcd, o_overflow, o_hex
  );

  modport slave (
    input  i_start, i_bin,
    output o_busy, o_done, o_bcd, o_overflow, o_hex
  );
endinterface
`default_nettype wire

// File: rtl/bcd_display_converter.sv
`default_nettype none
// ============================================================================
// Module : bcd_display_converter
// Serial double-dabble binary-to-BCD with per-digit seven-segment decode.
// Rev    : 1.0
// ============================================================================
module bcd_display_converter #(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  bcd_display_converter_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BW    = 4 * DIGITS;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_work;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic [BW-1:0]    r_bcd;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_work_nxt;
  logic             w_sticky_nxt;

  genvar gi;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_work[4*gi +: 4] >= 4'd5) ?
                                (r_work[4*gi +: 4] + 4'd3) : r_work[4*gi +: 4];
    end
  endgenerate

  // Bit shifted out of the top digit means the value has reached 10^DIGITS.
  assign w_work_nxt   = {w_adj[BW-2:0], r_bin[WIDTH-1]};
  assign w_sticky_nxt = r_sticky | w_adj[BW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bin    <= '0;
      r_work   <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_bcd    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_bin    <= bus.i_bin;
            r_work   <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= CNT_W'(WIDTH);
            r_busy   <= 1'b1;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bin    <= r_bin << 1;
          r_work   <= w_work_nxt;
          r_sticky <= w_sticky_nxt;
          r_cnt    <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_bcd   <= w_work_nxt;
            r_ovf   <= w_sticky_nxt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
  assign bus.o_bcd      = r_bcd;
  assign bus.o_overflow = r_ovf;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h3F;
      4'd1:    f_seg = 7'h06;
      4'd2:    f_seg = 7'h5B;
      4'd3:    f_seg = 7'h4F;
      4'd4:    f_seg = 7'h66;
      4'd5:    f_seg = 7'h6D;
      4'd6:    f_seg = 7'h7D;
      4'd7:    f_seg = 7'h07;
      4'd8:    f_seg = 7'h7F;
      4'd9:    f_seg = 7'h6F;
      default: f_seg = 7'h00;
    endcase
  endfunction

  // w_lead[i]: digit i and every digit above it are zero.
  logic [DIGITS:1] w_lead;
  assign w_lead[DIGITS] = 1'b1;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_seg
      logic [3:0] w_dig;
      logic       w_blank;
      logic [6:0] w_pat;

      assign w_dig = r_bcd[4*gi +: 4];

      if (gi > 0) begin : g_lz
        assign w_lead[gi] = w_lead[gi+1] & (w_dig == 4'd0);
        assign w_blank    = BLANK_LZ & w_lead[gi];
      end else begin : g_d0
        assign w_blank = 1'b0;
      end

      assign w_pat = r_ovf   ? 7'h40 :
                     w_blank ? 7'h00 : f_seg(w_dig);
      assign bus.o_hex[7*gi +: 7] = SEG_ACTIVE_LOW ? ~w_pat : w_pat;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_converter.sv
`default_nettype none
// ============================================================================
// Module : tb_bcd_display_converter
// Scoreboard bench driving four converter configurations with shared stimulus.
// Rev    : 1.0
// ============================================================================
module tb_bcd_display_converter;
  localparam int W = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [7:0] bin   = 8'd0;

  int checks = 0;
  int errors = 0;

  int          m_rem  = 0;
  logic        m_done = 1'b0;
  int unsigned exp_q[$];

  logic [6:0] SEG [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  // A: default, B: no blanking, C: two digits, D: active-low segments
  bcd_display_converter_if #(.WIDTH(W), .DIGITS(3)) if_a ();
  bcd_display_converter_if #(.WIDTH(W), .DIGITS(3)) if_b ();
  bcd_display_converter_if #(.WIDTH(W), .DIGITS(2)) if_c ();
  bcd_display_converter_if #(.WIDTH(W), .DIGITS(3)) if_d ();

  assign if_a.i_start = start;  assign if_a.i_bin = bin;
  assign if_b.i_start = start;  assign if_b.i_bin = bin;
  assign if_c.i_start = start;  assign if_c.i_bin = bin;
  assign if_d.i_start = start;  assign if_d.i_bin = bin;

  bcd_display_converter #(.WIDTH(W), .DIGITS(3), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  bcd_display_converter #(.WIDTH(W), .DIGITS(3), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  bcd_display_converter #(.WIDTH(W), .DIGITS(2), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
  bcd_display_converter #(.WIDTH(W), .DIGITS(3), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1))
    dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

  function automatic int unsigned pow10(input int n);
    int unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] ref_bcd(input int unsigned v, input int nd);
    logic [31:0] r = '0;
    int unsigned t = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_hex(input int unsigned v, input int nd,
                                          input bit blank, input bit alow);
    logic [31:0] r   = '0;
    logic [6:0]  seg;
    int unsigned p   = 1;
    bit          ovf = (v >= pow10(nd));
    for (int i = 0; i < nd; i++) begin
      if (ovf)                          seg = 7'h40;
      else if (blank && i > 0 && v < p) seg = 7'h00;
      else                              seg = SEG[(v / p) % 10];
      r[7*i +: 7] = alow ? ~seg : seg;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timing model: an accepted start yields a result exactly W edges later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      exp_q.delete();
    end else begin
      m_done <= (m_rem == 1);
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
      end else if (start) begin
        exp_q.push_back(int'(bin));
        m_rem <= W;
      end
    end
  end

  always @(negedge clk) begin
    int unsigned v;
    if (!rst) begin
      chk("busy", 32'(if_a.o_busy), 32'(m_rem != 0));
      chk("done", 32'(if_a.o_done), 32'(m_done));
      chk("done_sync", 32'({if_b.o_done, if_c.o_done, if_d.o_done}), 32'({3{if_a.o_done}}));
      if (if_a.o_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
        end else begin
          v = exp_q.pop_front();
          chk("bcd_a", 32'(if_a.o_bcd),      ref_bcd(v, 3));
          chk("ovf_a", 32'(if_a.o_overflow), 32'(v >= pow10(3)));
          chk("hex_a", 32'(if_a.o_hex),      ref_hex(v, 3, 1'b1, 1'b0));
          chk("hex_b", 32'(if_b.o_hex),      ref_hex(v, 3, 1'b0, 1'b0));
          chk("bcd_c", 32'(if_c.o_bcd),      ref_bcd(v, 2));
          chk("ovf_c", 32'(if_c.o_overflow), 32'(v >= pow10(2)));
          chk("hex_c", 32'(if_c.o_hex),      ref_hex(v, 2, 1'b1, 1'b0));
          chk("hex_d", 32'(if_d.o_hex),      ref_hex(v, 3, 1'b1, 1'b1));
        end
      end
    end
  end

  task automatic chk_reset_state();
    chk("rst_busy", 32'(if_a.o_busy), 32'd0);
    chk("rst_done", 32'({if_a.o_done, if_b.o_done, if_c.o_done, if_d.o_done}), 32'd0);
    chk("rst_bcd",  32'(if_a.o_bcd), 32'd0);
    chk("rst_ovf",  32'({if_a.o_overflow, if_c.o_overflow}), 32'd0);
    chk("rst_hex_a", 32'(if_a.o_hex), ref_hex(0, 3, 1'b1, 1'b0));
    chk("rst_hex_b", 32'(if_b.o_hex), ref_hex(0, 3, 1'b0, 1'b0));
    chk("rst_hex_c", 32'(if_c.o_hex), ref_hex(0, 2, 1'b1, 1'b0));
    chk("rst_hex_d", 32'(if_d.o_hex), ref_hex(0, 3, 1'b1, 1'b1));
  endtask

  task automatic wait_not_busy(input string nm);
    int n = 0;
    while (if_a.o_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s busy_timeout actual=1 required=0", nm);
    end
  endtask

  task automatic conv(input logic [7:0] v);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = 8'($urandom);
    wait_not_busy("conv");
  endtask

  initial begin
    int n;
    logic [7:0] dir [0:8] = '{8'd255, 8'd7, 8'd0, 8'd105, 8'd100, 8'd99, 8'd8, 8'd42, 8'd10};

    repeat (3) @(negedge clk);
    chk_reset_state();
    #2 rst = 1'b0;

    foreach (dir[i]) conv(dir[i]);

    // Second start while busy must be ignored.
    @(negedge clk); start = 1'b1; bin = 8'd123;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; bin = 8'd45;
    @(negedge clk); start = 1'b0;
    wait_not_busy("ignore");
    repeat (3) @(negedge clk);

    // Back-to-back: start presented in the Done cycle.
    @(negedge clk); start = 1'b1; bin = 8'd200;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!if_a.o_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 32'(if_a.o_done), 32'd1);
    start = 1'b1; bin = 8'd42;
    @(negedge clk); start = 1'b0;
    wait_not_busy("b2b");

    // Start held high with a changing Bin.
    start = 1'b1;
    repeat (40) begin
      @(negedge clk);
      bin = 8'($urandom);
    end
    start = 1'b0;
    @(negedge clk);
    wait_not_busy("held");

    // Reset three cycles into a conversion.
    @(negedge clk); start = 1'b1; bin = 8'd200;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_state();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    conv(8'd200);

    repeat (150) begin
      @(negedge clk);
      start = 1'b1;
      bin   = 8'($urandom_range(0, 255));
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    @(negedge clk);
    wait_not_busy("random");
    repeat (2) @(negedge clk);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
